// File: rtl/sm4_out_buffer.sv
// Result buffer behind the SM4 pipeline: credit-based admission, a DEPTH-entry
// 128-bit FIFO, and a 32-bit valid/ready serializer (most significant word first).
module sm4_out_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                         CLK_i,
    input  logic                         RST_N_i,
    input  logic                         ISSUE_i,
    input  logic [127:0]                 ENG_DAT_i,
    input  logic                         ENG_VALID_i,
    output logic                         CREDIT_o,
    output logic [31:0]                  WORD_o,
    output logic                         WORD_VALID_o,
    input  logic                         WORD_READY_i,
    output logic                         LAST_o,
    output logic [$clog2(DEPTH+1)-1:0]   OCC_o,
    output logic                         OVF_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [127:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] occ, res;
    logic [1:0]    idx;
    logic          ovf;

    logic          xfer, pop, full, wr_ok, issue_ok, credit;
    logic [127:0]  head;

    assign head     = mem[rd_ptr];
    assign full     = (occ == DEPTH_C);
    assign xfer     = (occ != '0) & WORD_READY_i;
    assign pop      = xfer & (idx == 2'd3);
    // A slot freed by this cycle's final-word transfer may be reused at once.
    assign credit   = (res < DEPTH_C) | ((res == DEPTH_C) & pop);
    assign issue_ok = ISSUE_i & credit;
    assign wr_ok    = ENG_VALID_i & (~full | pop);

    always_comb begin
        WORD_o = head[31:0];
        case (idx)
            2'd0: WORD_o = head[127:96];
            2'd1: WORD_o = head[95:64];
            2'd2: WORD_o = head[63:32];
            default: WORD_o = head[31:0];
        endcase
    end

    assign CREDIT_o     = credit;
    assign WORD_VALID_o = (occ != '0);
    assign LAST_o       = (occ != '0) & (idx == 2'd3);
    assign OCC_o        = occ;
    assign OVF_o        = ovf;

    // Storage carries no reset; contents are only observed once occ says so.
    always_ff @(posedge CLK_i) begin
        if (wr_ok) mem[wr_ptr] <= ENG_DAT_i;
    end

    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            res    <= '0;
            idx    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            if (xfer)  idx    <= idx + 2'd1;

            if (wr_ok & ~pop)      occ <= occ + CW'(1);
            else if (pop & ~wr_ok) occ <= occ - CW'(1);

            // Guard against underflow if the engine writes without a reservation.
            if (issue_ok & ~pop)                      res <= res + CW'(1);
            else if (pop & ~issue_ok & (res != '0))   res <= res - CW'(1);

            if ((ISSUE_i & ~credit) | (ENG_VALID_i & ~wr_ok)) ovf <= 1'b1;
        end
    end
endmodule

// File: doc/sm4_out_buffer.md
SM4_OUT_BUFFER -- requirements
Module: sm4_out_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of 128-bit result entries held; legal values 2, 4, 8, 16.
REQ-002 CLK_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 RST_N_i  input  1  reset, asynchronous, active-low.
REQ-004 ISSUE_i  input  1  pulse: one block is entering the SM4 pipeline this cycle (same cycle as the pipeline's DAT_VALID).
REQ-005 ENG_DAT_i  input  128  ciphertext bus from the SM4 pipeline output.
REQ-006 ENG_VALID_i  input  1  pipeline output-ready strobe; ENG_DAT_i is valid while high.
REQ-007 CREDIT_o  output  1  high = upstream may assert ISSUE_i this cycle.
REQ-008 WORD_o  output  32  serialized result word.
REQ-009 WORD_VALID_o  output  1  WORD_o valid.
REQ-010 WORD_READY_i  input  1  consumer accepts WORD_o; a transfer occurs on WORD_VALID_o & WORD_READY_i.
REQ-011 LAST_o  output  1  high with the 4th (final) word of a block.
REQ-012 OCC_o  output  clog2(DEPTH+1)  number of entries stored (written, not yet fully drained).
REQ-013 OVF_o  output  1  sticky error: credit violation or write into a full buffer.

Function
REQ-014 The block SHALL absorb the non-stallable SM4 pipeline output into a DEPTH-entry FIFO and drain it as 32-bit words under valid/ready backpressure.
REQ-015 Reservation counter RES (0..DEPTH) SHALL count blocks in flight plus blocks stored: +1 on accepted ISSUE_i, -1 on the LAST word transfer, unchanged when both occur in the same cycle.
REQ-016 CREDIT_o SHALL be combinational: RES < DEPTH, or RES == DEPTH with a LAST word transfer occurring this cycle.
REQ-017 ISSUE_i with CREDIT_o low SHALL NOT change RES and SHALL set OVF_o.
REQ-018 ENG_VALID_i high SHALL write ENG_DAT_i into the FIFO at the write pointer on that edge; write pointer wraps DEPTH-1 -> 0.
REQ-019 Write when full SHALL be accepted if a LAST word transfer pops the head that same cycle; otherwise the data SHALL be dropped, pointers unchanged, OVF_o set.
REQ-020 WORD_VALID_o SHALL equal (OCC_o != 0); first word visible the cycle after the write edge (1-cycle latency), never same-cycle bypass.
REQ-021 Word index IDX (2 bits) SHALL select WORD_o = head[127:96], [95:64], [63:32], [31:0] for IDX 0,1,2,3 (most significant word first).
REQ-022 IDX SHALL advance only on a transfer; on the transfer with IDX=3 it SHALL wrap to 0 and the head entry SHALL be popped (read pointer +1 with wrap).
REQ-023 LAST_o SHALL equal WORD_VALID_o & (IDX == 3).
REQ-024 WORD_o, IDX and LAST_o SHALL hold stable while WORD_VALID_o & ~WORD_READY_i.
REQ-025 Simultaneous write and pop SHALL leave OCC_o unchanged; write and no pop +1; pop and no write -1.
REQ-026 OVF_o SHALL remain set until reset; its setting SHALL NOT otherwise alter datapath behaviour.

Reset
REQ-027 RST_N_i low SHALL immediately force: RES=0, OCC_o=0, pointers=0, IDX=0, WORD_VALID_o=0, LAST_o=0, OVF_o=0, CREDIT_o=1.
REQ-028 FIFO storage SHALL NOT require reset; WORD_o is don't-care while WORD_VALID_o=0.
REQ-029 Reset asserted mid-block SHALL discard partial drains and in-flight reservations; the first transfer after release SHALL be IDX=0 of a newly written entry.

Verification
REQ-030 Single block: ISSUE_i once, 32 cycles later ENG_VALID_i with 681EDF34D206965E86B3E94F536E4246, WORD_READY_i=1 -> words 681EDF34, D206965E, 86B3E94F, 536E4246 on 4 consecutive cycles, LAST_o only on 536E4246, OCC_o back to 0, RES 0.
REQ-031 Credit exhaustion: DEPTH=4, WORD_READY_i=0, ISSUE_i on 4 consecutive cycles -> CREDIT_o low after 4th; 5th ISSUE_i -> OVF_o=1, RES stays 4.
REQ-032 Credit reuse: RES=4, ISSUE_i in same cycle as LAST transfer -> CREDIT_o high that cycle, RES stays 4, OVF_o=0.
REQ-033 Backpressure: WORD_READY_i toggling 1,0,0,1,... during a drain -> WORD_o stable while stalled, exactly 4 transfers per block, order preserved over 8 back-to-back blocks with pointer wrap.
REQ-034 Full-write: 4 entries stored, ENG_VALID_i without pop -> data dropped, OVF_o=1, OCC_o=4; same with concurrent LAST pop -> accepted, OVF_o=0.
REQ-035 Reset mid-drain after 2 words -> all outputs at reset values asynchronously; next block drains from its word 0.
